iter_controller: RTL and testbench

Parametrised Moore controller for the iterative neural datapath. It sequences weight/input initialisation, a per-channel multiply-accumulate sweep across N_CH channels, a MAC pipeline drain, accumulator write-back and a convergence check, repeating until the datapath reports completion. Compared with the single-channel fixed-latency controller, it adds channel indexing, configurable MAC latency, an iteration counter, busy status and an optional iteration-limit timeout. It sits beside the datapath and drives its load/select strobes.

---
 rtl/iter_ctrl_pkg.sv | 23 ++
 rtl/iter_controller_mod_counter.sv | 38 +++
 rtl/iter_controller.sv | 163 ++++++++++++++++
 tb/tb_iter_controller.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iter_ctrl_pkg.sv
// Shared types and width helpers for the iterative datapath controller.
package iter_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        WB    = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_e;

    // Index width for a counter reaching n-1; never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int it_width(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/iter_controller_mod_counter.sv
// Up-counter with synchronous clear and enable; holds at MAX until cleared.
module mod_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MAX);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != TERM)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == TERM);

endmodule

// File: rtl/iter_controller.sv
// Moore controller sequencing init, per-channel MAC sweep, drain, write-back
// and convergence check. Define ITER_CTRL_TIMEOUT_EN to enable the MAX_ITER limit.
module iter_controller
    import iter_ctrl_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int MAC_LAT  = 2,
    parameter  int MAX_ITER = 15,
    localparam int CH_W     = ch_width(N_CH),
    localparam int IT_W     = it_width(MAX_ITER)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_finished,
    output logic            init_w,
    output logic            init_x,
    output logic            load_a,
    output logic            load_sel,
    output logic            mac_en,
    output logic [CH_W-1:0] ch_sel,
    output logic            busy,
    output logic [IT_W-1:0] iter_cnt,
    output logic            done,
    output logic            timeout
);

    localparam int LAT_W   = ch_width(MAC_LAT);
    localparam int LAT_MAX = (MAC_LAT > 0) ? MAC_LAT - 1 : 0;

    state_e          state_q, state_d;
    logic [IT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [CH_W-1:0] ch_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic            ch_tc, lat_tc;
    logic            ch_clr, ch_en, lat_clr, lat_en;
    logic            at_limit;
    logic            unused_lat;

    // Channel counter is re-armed in INIT and in every CHECK so RUN starts at 0.
    assign ch_clr  = (state_q == INIT) || (state_q == CHECK);
    assign ch_en   = (state_q == RUN);
    assign lat_clr = (state_q != DRAIN);
    assign lat_en  = (state_q == DRAIN);

    mod_counter #(.WIDTH(CH_W), .MAX(N_CH - 1)) u_ch_cnt (
        .clk (clk),
        .rst (rst),
        .clr (ch_clr),
        .en  (ch_en),
        .cnt (ch_cnt),
        .tc  (ch_tc)
    );

    mod_counter #(.WIDTH(LAT_W), .MAX(LAT_MAX)) u_lat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (lat_clr),
        .en  (lat_en),
        .cnt (lat_cnt),
        .tc  (lat_tc)
    );

    assign unused_lat = ^lat_cnt;

`ifdef ITER_CTRL_TIMEOUT_EN
    logic timeout_q, timeout_d;
    assign at_limit = (iter_cnt_q == IT_W'(MAX_ITER));
`else
    assign at_limit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
`ifdef ITER_CTRL_TIMEOUT_EN
        timeout_d  = timeout_q;
`endif
        case (state_q)
            IDLE: if (start) state_d = INIT;
            INIT: begin
                iter_cnt_d = '0;
`ifdef ITER_CTRL_TIMEOUT_EN
                timeout_d  = 1'b0;
`endif
                if (!start) state_d = RUN;
            end
            RUN:   if (ch_tc) state_d = (MAC_LAT == 0) ? WB : DRAIN;
            DRAIN: if (lat_tc) state_d = WB;
            WB: begin
                if (iter_cnt_q != '1) iter_cnt_d = iter_cnt_q + IT_W'(1);
                state_d = CHECK;
            end
            CHECK: begin
                // Convergence takes priority over the iteration limit.
                if (is_finished) begin
                    state_d = DONE;
                end else if (at_limit) begin
                    state_d = DONE;
`ifdef ITER_CTRL_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end else begin
                    state_d = RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            iter_cnt_q <= '0;
`ifdef ITER_CTRL_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
`ifdef ITER_CTRL_TIMEOUT_EN
            timeout_q  <= timeout_d;
`endif
        end
    end

    always_comb begin
        init_w   = 1'b0;
        init_x   = 1'b0;
        load_a   = 1'b0;
        load_sel = 1'b0;
        mac_en   = 1'b0;
        ch_sel   = '0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state_q)
            INIT: begin
                init_w   = 1'b1;
                init_x   = 1'b1;
                load_a   = 1'b1;
                load_sel = 1'b1;
            end
            RUN: begin
                mac_en = 1'b1;
                ch_sel = ch_cnt;
            end
            DRAIN:   ch_sel = ch_cnt;
            WB:      load_a = 1'b1;
            CHECK:   ;
            DONE:    done   = 1'b1;
            default: busy   = 1'b0;
        endcase
    end

    assign iter_cnt = iter_cnt_q;
`ifdef ITER_CTRL_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_iter_controller.sv
// Self-checking bench for iter_controller: position-based reference model plus
// directed scenarios with hand-computed cycle counts and randomized traffic.
module tb_iter_controller;

    localparam int N_CH     = 4;
    localparam int MAC_LAT  = 2;
    localparam int MAX_ITER = 15;
    localparam int L        = N_CH + MAC_LAT + 2;
    localparam int IT_MAX   = 15;
`ifdef ITER_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_INIT = 1;
    localparam int M_ITER = 2;
    localparam int M_DONE = 3;

    logic clk = 1'b0;
    logic rst, start, is_finished;
    logic init_w, init_x, load_a, load_sel, mac_en, busy, done, timeout;
    logic [1:0] ch_sel;
    logic [3:0] iter_cnt;

    logic start1, fin1;
    logic init_w1, init_x1, load_a1, load_sel1, mac_en1, busy1, done1, timeout1;
    logic [0:0] ch_sel1;
    logic [3:0] iter1;

    int checks = 0;
    int errors = 0;

    int m_mode, m_pos, m_iter, m_to;

    int r_done_cyc, r_bursts, r_loads, r_nch, r_iter, r_to;
    int r_ch [8];

    always #5 clk = ~clk;

    iter_controller #(.N_CH(N_CH), .MAC_LAT(MAC_LAT), .MAX_ITER(MAX_ITER)) u_dut (
        .clk(clk), .rst(rst), .start(start), .is_finished(is_finished),
        .init_w(init_w), .init_x(init_x), .load_a(load_a), .load_sel(load_sel),
        .mac_en(mac_en), .ch_sel(ch_sel), .busy(busy), .iter_cnt(iter_cnt),
        .done(done), .timeout(timeout)
    );

    iter_controller #(.N_CH(1), .MAC_LAT(0), .MAX_ITER(15)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .is_finished(fin1),
        .init_w(init_w1), .init_x(init_x1), .load_a(load_a1), .load_sel(load_sel1),
        .mac_en(mac_en1), .ch_sel(ch_sel1), .busy(busy1), .iter_cnt(iter1),
        .done(done1), .timeout(timeout1)
    );

    // Reference: an iteration is L cycles; position 0..N_CH-1 issue MACs,
    // L-2 is write-back and L-1 is the convergence check.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_IDLE;
            m_pos  <= 0;
            m_iter <= 0;
            m_to   <= 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) m_mode <= M_INIT;
                M_INIT: begin
                    m_iter <= 0;
                    m_to   <= 0;
                    if (!start) begin
                        m_mode <= M_ITER;
                        m_pos  <= 0;
                    end
                end
                M_ITER: begin
                    if (m_pos == L - 2) m_iter <= (m_iter == IT_MAX) ? m_iter : m_iter + 1;
                    if (m_pos == L - 1) begin
                        if (is_finished) begin
                            m_mode <= M_DONE;
                        end else if (TIMEOUT_ON && m_iter == MAX_ITER) begin
                            m_mode <= M_DONE;
                            m_to   <= 1;
                        end else begin
                            m_pos <= 0;
                        end
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic compare_all();
        int e_ch;
        bit in_iter;
        in_iter = (m_mode == M_ITER);
        if (in_iter && m_pos < N_CH) e_ch = m_pos;
        else if (in_iter && m_pos < N_CH + MAC_LAT) e_ch = N_CH - 1;
        else e_ch = 0;
        chk("busy",     32'(busy),     32'(m_mode != M_IDLE));
        chk("init_w",   32'(init_w),   32'(m_mode == M_INIT));
        chk("init_x",   32'(init_x),   32'(m_mode == M_INIT));
        chk("load_sel", 32'(load_sel), 32'(m_mode == M_INIT));
        chk("load_a",   32'(load_a),   32'(m_mode == M_INIT || (in_iter && m_pos == L - 2)));
        chk("mac_en",   32'(mac_en),   32'(in_iter && m_pos < N_CH));
        chk("ch_sel",   32'(ch_sel),   32'(e_ch));
        chk("done",     32'(done),     32'(m_mode == M_DONE));
        chk("iter_cnt", 32'(iter_cnt), 32'(m_iter));
        chk("timeout",  32'(timeout),  32'(m_to));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            if (m_mode == M_IDLE) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) fail_bound("wait_idle");
    endtask

    // One-cycle start, then is_finished asserted only at CHECK number k_fin
    // (0 = never); random elsewhere since it is ignored outside CHECK.
    task automatic do_run(input int k_fin, input int bound);
        int  ncheck;
        logic prev_mac;
        r_done_cyc = 0; r_bursts = 0; r_loads = 0; r_nch = 0;
        r_iter = -1; r_to = -1; ncheck = 0; prev_mac = 1'b0;
        start = 1'b1;
        is_finished = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= bound; c++) begin
            if (c > 1) tick();
            if (m_mode == M_ITER && m_pos == L - 1) begin
                ncheck++;
                is_finished = (ncheck == k_fin);
            end else begin
                is_finished = 1'($urandom_range(0, 1));
            end
            if (mac_en && !prev_mac) r_bursts++;
            prev_mac = mac_en;
            if (load_a && !init_w) r_loads++;
            if (mac_en && r_nch < 8) begin
                r_ch[r_nch] = int'(ch_sel);
                r_nch++;
            end
            if (done) begin
                r_done_cyc = c;
                r_iter = int'(iter_cnt);
                r_to = int'(timeout);
                break;
            end
        end
        if (r_done_cyc == 0) fail_bound("do_run");
        is_finished = 1'b0;
        tick();
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [4:0] e_init, e_mac, e_load, e_done;
        int  n;
        bit  found;

        rst = 1'b1; start = 1'b0; is_finished = 1'b0; start1 = 1'b0; fin1 = 1'b0;
        tick();
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_iter", 32'(iter_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Single iteration, default parameters.
        do_run(1, 40);
        chk("s1_done_cycle", 32'(r_done_cyc), 32'd10);
        chk("s1_nch", 32'(r_nch), 32'd4);
        for (int i = 0; i < 4; i++) chk("s1_ch_seq", 32'(r_ch[i]), 32'(i));
        chk("s1_iter", 32'(r_iter), 32'd1);
        chk("s1_timeout", 32'(r_to), 32'd0);
        chk("s1_iter_hold", 32'(iter_cnt), 32'd1);

        // start held for five cycles stretches INIT.
        start = 1'b1;
        is_finished = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (init_w) n++;
        end
        start = 1'b0;
        tick();
        chk("s2_init_cycles", 32'(n), 32'd5);
        chk("s2_run_after", 32'(mac_en), 32'd1);
        chk("s2_init_off", 32'(init_w), 32'd0);
        wait_idle(40);

        // Converges at the third CHECK.
        do_run(3, 60);
        chk("s3_bursts", 32'(r_bursts), 32'd3);
        chk("s3_loads", 32'(r_loads), 32'd3);
        chk("s3_iter", 32'(r_iter), 32'd3);
        chk("s3_done_cycle", 32'(r_done_cyc), 32'd26);

`ifdef ITER_CTRL_TIMEOUT_EN
        do_run(0, 200);
        chk("s4_to_done_cycle", 32'(r_done_cyc), 32'd122);
        chk("s4_to_iter", 32'(r_iter), 32'd15);
        chk("s4_to_flag", 32'(r_to), 32'd1);
        do_run(15, 200);
        chk("s4_fin_wins_cycle", 32'(r_done_cyc), 32'd122);
        chk("s4_fin_wins_iter", 32'(r_iter), 32'd15);
        chk("s4_fin_wins_flag", 32'(r_to), 32'd0);
`else
        // No limit: seventeen iterations, counter saturates at 15.
        do_run(17, 200);
        chk("s4_nolimit_cycle", 32'(r_done_cyc), 32'd138);
        chk("s4_nolimit_iter", 32'(r_iter), 32'd15);
        chk("s4_nolimit_to", 32'(r_to), 32'd0);
`endif

        // N_CH=1, MAC_LAT=0 instance: INIT, RUN, WB, CHECK, DONE.
        e_init = 5'b00001; e_mac = 5'b00010; e_load = 5'b00101; e_done = 5'b10000;
        start1 = 1'b1; fin1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            chk("d1_init_w", 32'(init_w1), 32'(e_init[c-1]));
            chk("d1_init_x", 32'(init_x1), 32'(e_init[c-1]));
            chk("d1_load_sel", 32'(load_sel1), 32'(e_init[c-1]));
            chk("d1_mac_en", 32'(mac_en1), 32'(e_mac[c-1]));
            chk("d1_load_a", 32'(load_a1), 32'(e_load[c-1]));
            chk("d1_done", 32'(done1), 32'(e_done[c-1]));
            chk("d1_busy", 32'(busy1), 32'd1);
            chk("d1_ch_sel", 32'(ch_sel1), 32'd0);
        end
        tick();
        chk("d1_busy_after", 32'(busy1), 32'd0);
        chk("d1_iter", 32'(iter1), 32'd1);
        chk("d1_timeout", 32'(timeout1), 32'd0);
        fin1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) tick();
            fin1 = (c == 7);
            chk("d1b_done", 32'(done1), 32'(c == 8));
            chk("d1b_mac", 32'(mac_en1), 32'(c == 2 || c == 5));
        end
        fin1 = 1'b0;
        tick();
        chk("d1b_iter", 32'(iter1), 32'd2);
        chk("d1b_busy_after", 32'(busy1), 32'd0);

        // Reset in the DRAIN of the second iteration.
        is_finished = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (m_mode == M_ITER && m_iter == 1 && m_pos == N_CH) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) fail_bound("s6_reach_drain");
        chk("s6_pre_iter", 32'(iter_cnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_ch_sel", 32'(ch_sel), 32'd0);
        chk("s6_rst_iter", 32'(iter_cnt), 32'd0);
        chk("s6_rst_strobes", 32'({init_w, init_x, load_a, load_sel, mac_en, done, timeout}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("s6_idle_after", 32'(busy), 32'd0);
        do_run(1, 40);
        chk("s6_done_cycle", 32'(r_done_cyc), 32'd10);
        chk("s6_iter", 32'(r_iter), 32'd1);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 2500; c++) begin
            tick();
            start = ($urandom_range(0, 5) == 0);
            if (c < 1500) is_finished = ($urandom_range(0, 3) == 0);
            else          is_finished = ($urandom_range(0, 40) == 0);
        end
        start = 1'b0;
        is_finished = 1'b1;
        wait_idle(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
